// File: rtl/iob_wb_arbiter2.sv
// Round-robin arbiter of two Wishbone classic ports onto one IOb master. Latency: request to valid_o 1 cycle, ready_i to ack 1 cycle.
// The losing port is held off with no ack until the owner's transfer ends. Define IOB_WB_ARB_TIMEOUT_EN to add a watchdog that errors out stalled transfers.
module iob_wb_arbiter2 #(
  parameter int ADDR_W    = 32,
  parameter int DATA_W    = 32,
  parameter int TIMEOUT_W = 8
) (
  input  logic                clk_i,
  input  logic                arst_i,
  input  logic [ADDR_W-1:0]   wb0_adr_i,
  input  logic [DATA_W/8-1:0] wb0_sel_i,
  input  logic                wb0_we_i,
  input  logic                wb0_cyc_i,
  input  logic                wb0_stb_i,
  input  logic [DATA_W-1:0]   wb0_dat_i,
  output logic                wb0_ack_o,
  output logic                wb0_err_o,
  output logic [DATA_W-1:0]   wb0_dat_o,
  input  logic [ADDR_W-1:0]   wb1_adr_i,
  input  logic [DATA_W/8-1:0] wb1_sel_i,
  input  logic                wb1_we_i,
  input  logic                wb1_cyc_i,
  input  logic                wb1_stb_i,
  input  logic [DATA_W-1:0]   wb1_dat_i,
  output logic                wb1_ack_o,
  output logic                wb1_err_o,
  output logic [DATA_W-1:0]   wb1_dat_o,
  output logic                valid_o,
  output logic [ADDR_W-1:0]   addr_o,
  output logic [DATA_W-1:0]   wdata_o,
  output logic [DATA_W/8-1:0] wstrb_o,
  input  logic [DATA_W-1:0]   rdata_i,
  input  logic                ready_i,
  output logic [1:0]          grant_o
);
  typedef enum logic [1:0] {IDLE, REQ, ACK} state_t;

  state_t              state, state_nxt;
  logic                req0, req1, pick;
  logic                owner, last;
  logic                ack_q, err_q;
  logic                tmo;
  logic [ADDR_W-1:0]   addr_q;
  logic [DATA_W-1:0]   wdata_q, dat0_q, dat1_q;
  logic [DATA_W/8-1:0] wstrb_q;

  assign req0 = wb0_cyc_i & wb0_stb_i;
  assign req1 = wb1_cyc_i & wb1_stb_i;
  // On a tie the port not granted last wins; a lone request always wins.
  assign pick = (req0 & req1) ? ~last : req1;

`ifdef IOB_WB_ARB_TIMEOUT_EN
  logic [TIMEOUT_W-1:0] tmo_cnt;

  assign tmo = (state == REQ) && !ready_i && (tmo_cnt == {TIMEOUT_W{1'b1}});

  always_ff @(posedge clk_i) begin
    if (arst_i || state != REQ) tmo_cnt <= '0;
    else if (!ready_i)          tmo_cnt <= tmo_cnt + 1'b1;
  end
`else
  assign tmo = 1'b0;
`endif

  always_ff @(posedge clk_i) begin
    if (arst_i) state <= IDLE;
    else        state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:    if (req0 | req1) state_nxt = REQ;
      REQ:     if (ready_i | tmo) state_nxt = ACK;
      ACK:     state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk_i) begin
    if (arst_i) begin
      owner   <= 1'b0;
      last    <= 1'b1;
      ack_q   <= 1'b0;
      err_q   <= 1'b0;
      addr_q  <= '0;
      wdata_q <= '0;
      wstrb_q <= '0;
      dat0_q  <= '0;
      dat1_q  <= '0;
    end else begin
      ack_q <= 1'b0;
      err_q <= 1'b0;
      if (state == IDLE && (req0 | req1)) begin
        owner   <= pick;
        last    <= pick;
        addr_q  <= pick ? wb1_adr_i : wb0_adr_i;
        wdata_q <= pick ? wb1_dat_i : wb0_dat_i;
        wstrb_q <= pick ? (wb1_we_i ? wb1_sel_i : '0) : (wb0_we_i ? wb0_sel_i : '0);
      end
      // A watchdog expiry returns zero data and an error instead of an ack.
      if (state == REQ && (ready_i || tmo)) begin
        ack_q <= ready_i;
        err_q <= ~ready_i;
        if (owner) dat1_q <= ready_i ? rdata_i : '0;
        else       dat0_q <= ready_i ? rdata_i : '0;
      end
    end
  end

  always_comb begin
    valid_o = (state == REQ);
    grant_o = 2'b00;
    if (state != IDLE) grant_o = owner ? 2'b10 : 2'b01;
    // Responses are dropped if the requester abandoned its cycle.
    wb0_ack_o = ack_q & ~owner & wb0_cyc_i;
    wb1_ack_o = ack_q &  owner & wb1_cyc_i;
    wb0_err_o = err_q & ~owner & wb0_cyc_i;
    wb1_err_o = err_q &  owner & wb1_cyc_i;
  end

  assign addr_o    = addr_q;
  assign wdata_o   = wdata_q;
  assign wstrb_o   = wstrb_q;
  assign wb0_dat_o = dat0_q;
  assign wb1_dat_o = dat1_q;
endmodule

// File: tb/tb_iob_wb_arbiter2.sv
// Bench for iob_wb_arbiter2: directed cases, then random traffic from both ports against a
// word memory and a shadow copy per port, with round-robin fairness tracked per grant.
module tb_iob_wb_arbiter2;
  logic        clk = 1'b0;
  logic        arst;
  logic [31:0] wb0_adr, wb1_adr, wb0_wdat, wb1_wdat, wb0_rdat, wb1_rdat;
  logic [3:0]  wb0_sel, wb1_sel;
  logic        wb0_we, wb1_we, wb0_cyc, wb1_cyc, wb0_stb, wb1_stb;
  logic        wb0_ack, wb1_ack, wb0_err, wb1_err;
  logic        valid, ready;
  logic [31:0] addr, wdata, rdata;
  logic [3:0]  wstrb;
  logic [1:0]  grant;
  int          n_checks = 0;
  int          n_fail = 0;

  always #5 clk = ~clk;

  iob_wb_arbiter2 dut (
    .clk_i(clk), .arst_i(arst),
    .wb0_adr_i(wb0_adr), .wb0_sel_i(wb0_sel), .wb0_we_i(wb0_we), .wb0_cyc_i(wb0_cyc),
    .wb0_stb_i(wb0_stb), .wb0_dat_i(wb0_wdat), .wb0_ack_o(wb0_ack), .wb0_err_o(wb0_err),
    .wb0_dat_o(wb0_rdat),
    .wb1_adr_i(wb1_adr), .wb1_sel_i(wb1_sel), .wb1_we_i(wb1_we), .wb1_cyc_i(wb1_cyc),
    .wb1_stb_i(wb1_stb), .wb1_dat_i(wb1_wdat), .wb1_ack_o(wb1_ack), .wb1_err_o(wb1_err),
    .wb1_dat_o(wb1_rdat),
    .valid_o(valid), .addr_o(addr), .wdata_o(wdata), .wstrb_o(wstrb),
    .rdata_i(rdata), .ready_i(ready), .grant_o(grant)
  );

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
    end
  endtask

  task automatic drive(input int p, input logic on, input logic we, input logic [31:0] adr,
                       input logic [3:0] sel, input logic [31:0] dat);
    if (p == 0) begin
      wb0_cyc = on; wb0_stb = on; wb0_we = we; wb0_adr = adr; wb0_sel = sel; wb0_wdat = dat;
    end else begin
      wb1_cyc = on; wb1_stb = on; wb1_we = we; wb1_adr = adr; wb1_sel = sel; wb1_wdat = dat;
    end
  endtask

  function automatic logic ack_of(input int p);
    return (p == 0) ? wb0_ack : wb1_ack;
  endfunction

  function automatic logic [31:0] dat_of(input int p);
    return (p == 0) ? wb0_rdat : wb1_rdat;
  endfunction

  logic [31:0] mem [64];
  logic [31:0] shadow [64];
  bit          act [2];
  logic        we_r [2];
  int          idx_r [2];
  logic [3:0]  sel_r [2];
  logic [31:0] dat_r [2];
  int          age [2];
  bit          pend_prev [2];

  initial begin
    int          acks;
    int          own;
    int          exp_o;
    int          last_owner;
    int          wait_cnt;
    bit          in_req;
    bit          abort;
    logic [1:0]  prev_grant;
    logic [31:0] rec_addr, rec_wdata, word;
    logic [3:0]  rec_wstrb;

    for (int i = 0; i < 64; i++) begin mem[i] = '0; shadow[i] = '0; end
    arst = 1'b1; ready = 1'b0; rdata = '0;
    drive(0, 0, 0, 0, 0, 0);
    drive(1, 0, 0, 0, 0, 0);
    repeat (3) @(negedge clk);
    check("rst_valid", valid, 0);
    check("rst_grant", grant, 0);
    check("rst_addr", addr, 0);
    check("rst_wdata", wdata, 0);
    check("rst_wstrb", wstrb, 0);
    check("rst_ack", {wb0_ack, wb1_ack, wb0_err, wb1_err}, 0);
    check("rst_dat0", wb0_rdat, 0);
    check("rst_dat1", wb1_rdat, 0);
    arst = 1'b0;

    // Single read on port 0, IOb completes in the first REQ cycle.
    @(negedge clk); drive(0, 1, 0, 32'h10, 4'hf, 32'hdeadbeef);
    @(negedge clk);
    check("rd_valid", valid, 1);
    check("rd_wstrb", wstrb, 0);
    check("rd_addr", addr, 32'h10);
    check("rd_grant", grant, 2'b01);
    ready = 1'b1; rdata = 32'hCAFE0001;
    @(negedge clk); ready = 1'b0;
    check("rd_ack0", wb0_ack, 1);
    check("rd_dat0", wb0_rdat, 32'hCAFE0001);
    check("rd_ack1", wb1_ack, 0);
    check("rd_valid_drop", valid, 0);
    drive(0, 0, 0, 0, 0, 0);
    @(negedge clk);
    check("rd_idle_grant", grant, 0);
    check("rd_idle_valid", valid, 0);

    // Write on port 1, IOb stalls four cycles.
    drive(1, 1, 1, 32'h84, 4'h3, 32'h12345678);
    @(negedge clk);
    acks = 0;
    for (int i = 0; i < 4; i++) begin
      check("wr_wdata", wdata, 32'h12345678);
      check("wr_wstrb", wstrb, 4'h3);
      check("wr_valid", valid, 1);
      check("wr_grant", grant, 2'b10);
      acks += int'(wb1_ack);
      @(negedge clk);
    end
    ready = 1'b1; rdata = 32'h0;
    @(negedge clk); ready = 1'b0;
    acks += int'(wb1_ack);
    drive(1, 0, 0, 0, 0, 0);
    @(negedge clk);
    acks += int'(wb1_ack);
    check("wr_ack_count", acks, 1);
    check("wr_idle_grant", grant, 0);

    // Both ports requesting continuously: grants must alternate starting with port 0.
    drive(0, 1, 0, 32'h20, 4'hf, 0);
    drive(1, 1, 0, 32'ha0, 4'hf, 0);
    for (int t = 0; t < 4; t++) begin
      own = t % 2;
      @(negedge clk);
      check("rr_grant", grant, (own == 1) ? 2'b10 : 2'b01);
      check("rr_valid", valid, 1);
      ready = 1'b1; rdata = t;
      @(negedge clk); ready = 1'b0;
      check("rr_ack_own", ack_of(own), 1);
      check("rr_ack_other", ack_of(1 - own), 0);
      check("rr_dat_own", dat_of(own), t);
      drive(own, 0, 0, 0, 0, 0);
      @(negedge clk);
      check("rr_idle_grant", grant, 0);
      if (t < 3) drive(own, 1, 0, (own == 1) ? 32'ha0 : 32'h20, 4'hf, 0);
    end
    drive(0, 0, 0, 0, 0, 0);
    drive(1, 0, 0, 0, 0, 0);

    // Port 0 abandons its cycle while the IOb transfer is pending.
    @(negedge clk); drive(0, 1, 0, 32'h30, 4'hf, 0);
    @(negedge clk);
    check("ab_grant", grant, 2'b01);
    drive(0, 0, 0, 0, 0, 0);
    @(negedge clk); ready = 1'b1;
    @(negedge clk); ready = 1'b0;
    check("ab_no_ack", wb0_ack, 0);
    check("ab_ack_grant", grant, 2'b01);
    @(negedge clk);
    check("ab_idle_grant", grant, 0);
    check("ab_idle_valid", valid, 0);

    // Reset while in REQ, followed by a stray ready.
    drive(1, 1, 0, 32'hb0, 4'hf, 0);
    @(negedge clk);
    check("rs_valid_before", valid, 1);
    arst = 1'b1; drive(1, 0, 0, 0, 0, 0);
    @(negedge clk);
    check("rs_valid", valid, 0);
    check("rs_grant", grant, 0);
    check("rs_dat1", wb1_rdat, 0);
    arst = 1'b0; ready = 1'b1; rdata = 32'h55aa55aa;
    @(negedge clk); ready = 1'b0;
    check("rs_stray_ack", {wb0_ack, wb1_ack}, 0);
    check("rs_stray_valid", valid, 0);
    @(negedge clk);
    check("rs_stray_ack2", {wb0_ack, wb1_ack}, 0);

    // Random traffic; port p owns words p*32..p*32+31.
    last_owner = 1; prev_grant = grant; in_req = 0; wait_cnt = 0; abort = 0;
    for (int p = 0; p < 2; p++) begin act[p] = 0; pend_prev[p] = 0; age[p] = 0; end
    for (int c = 0; c < 3000 && !abort; c++) begin
      @(negedge clk);
      if (grant != 2'b00 && prev_grant == 2'b00) begin
        if (pend_prev[0] && pend_prev[1]) exp_o = 1 - last_owner;
        else                              exp_o = pend_prev[1] ? 1 : 0;
        check("arb_grant", grant, (exp_o == 1) ? 2'b10 : 2'b01);
        last_owner = grant[1] ? 1 : 0;
      end
      prev_grant = grant;
      check("err_never", {wb0_err, wb1_err}, 0);

      ready = 1'b0;
      if (valid) begin
        if (!in_req) begin
          in_req = 1; rec_addr = addr; rec_wdata = wdata; rec_wstrb = wstrb;
          wait_cnt = $urandom_range(0, 3);
          check("route_grant", grant, addr[7] ? 2'b10 : 2'b01);
        end
        if (wait_cnt == 0) begin
          check("iob_addr_hold", addr, rec_addr);
          check("iob_wdata_hold", wdata, rec_wdata);
          check("iob_wstrb_hold", wstrb, rec_wstrb);
          word = mem[addr[7:2]];
          for (int b = 0; b < 4; b++) if (wstrb[b]) word[8*b +: 8] = wdata[8*b +: 8];
          mem[addr[7:2]] = word;
          rdata = word; ready = 1'b1; in_req = 0;
        end else begin
          wait_cnt--;
        end
      end

      for (int p = 0; p < 2; p++) begin
        if (act[p]) begin
          if (ack_of(p)) begin
            check("ack_owner", grant, (p == 1) ? 2'b10 : 2'b01);
            if (!we_r[p]) begin
              check("rand_rdata", dat_of(p), shadow[idx_r[p]]);
            end else begin
              word = shadow[idx_r[p]];
              for (int b = 0; b < 4; b++) if (sel_r[p][b]) word[8*b +: 8] = dat_r[p][8*b +: 8];
              shadow[idx_r[p]] = word;
            end
            act[p] = 0;
            drive(p, 0, 0, 0, 0, 0);
          end else begin
            age[p]++;
            if (age[p] > 200) begin
              n_fail++;
              $display("FAIL ack_timeout: port %0d waited %0d cycles, required at most 200", p, age[p]);
              abort = 1;
            end
          end
        end else begin
          check("stray_ack", ack_of(p), 0);
          if ($urandom_range(0, 2) == 0) begin
            act[p] = 1; age[p] = 0;
            we_r[p] = 1'($urandom_range(0, 1));
            idx_r[p] = p * 32 + $urandom_range(0, 31);
            sel_r[p] = 4'($urandom_range(0, 15));
            dat_r[p] = $urandom;
            drive(p, 1, we_r[p], 32'(idx_r[p] * 4), sel_r[p], dat_r[p]);
          end
        end
        pend_prev[p] = act[p];
      end
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end
endmodule
